ms_sound_bus_ctrl: RTL and testbench

Sequencer between the Music/Speech SOC-side request interface and the two sound chips on the Music/Speech cartridge. It turns single-cycle register-write requests into correctly phased YM2149 bus cycles (BDIR/BC latch-address then write-data), timed on the 1.78 MHz PSG enable. It queues SP0256 allophone requests and hands them to the speech chip under its INPUT_RDY handshake. It also produces the Music/Speech busy status bits that the parent returns on host reads.

---
 rtl/ms_ctrl_pkg.sv | 31 +++
 rtl/ms_allo_fifo.sv | 79 +++++++
 rtl/ms_sound_bus_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ms_sound_bus_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_ctrl_pkg.sv
// Shared types for the Music/Speech cartridge bus controller: FSM states and
// YM2149 {BDIR,BC} bus-mode encodings.
package ms_ctrl_pkg;

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_LATCH = 3'd1,
    P_GAP1  = 3'd2,
    P_WRITE = 3'd3,
    P_GAP2  = 3'd4
  } psg_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_WAIT = 2'd2
  } spk_state_t;

  localparam logic [1:0] BUS_INACT = 2'b00;
  localparam logic [1:0] BUS_LATCH = 2'b11;
  localparam logic [1:0] BUS_WRITE = 2'b10;

  function automatic logic [1:0] bus_mode(input psg_state_t s);
    case (s)
      P_LATCH: bus_mode = BUS_LATCH;
      P_WRITE: bus_mode = BUS_WRITE;
      default: bus_mode = BUS_INACT;
    endcase
  endfunction

endpackage

// File: rtl/ms_allo_fifo.sv
// Allophone queue: DEPTH-entry ring with MS_ALLO_FIFO_EN, else one holding register.
// Caller only pushes when accepted (!full || pop) and only pops when non-empty.
module ms_allo_fifo #(
  parameter int DW    = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;

`ifdef MS_ALLO_FIFO_EN
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  always_ff @(negedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
`else
  logic [DW-1:0] hold;
  logic          vld;

  // A push alongside a pop simply replaces the entry being handed out.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold <= '0;
      vld  <= 1'b0;
    end else if (clr) begin
      hold <= '0;
      vld  <= 1'b0;
    end else if (push) begin
      hold <= din;
      vld  <= 1'b1;
    end else if (pop) begin
      vld  <= 1'b0;
    end
  end

  assign dout  = hold;
  assign full  = vld;
  assign empty = !vld;
  assign count = CW'(vld);
`endif

endmodule

// File: rtl/ms_sound_bus_ctrl.sv
// Music/Speech sequencer: phased YM2149 writes on PSG_CE and SP0256 allophone hand-off.
// Queue depth selected by MS_ALLO_FIFO_EN (undefined: single holding register).
module ms_sound_bus_ctrl
  import ms_ctrl_pkg::*;
#(
  parameter int HOLD_TICKS   = 2,
  parameter int ALLO_DEPTH   = 4,
  parameter int TRIG_TIMEOUT = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SOFT_RST,
  input  logic       CLK_EN,
  input  logic       PSG_CE,
  input  logic       PSG_REQ,
  input  logic [3:0] PSG_ADDR,
  input  logic [7:0] PSG_DATA,
  input  logic       SPK_REQ,
  input  logic [5:0] SPK_ALLO,
  input  logic       SP_INPUT_RDY,
  output logic       YM_BDIR,
  output logic       YM_BC,
  output logic [7:0] YM_DATA,
  output logic [5:0] SP_ALLO,
  output logic       SP_TRIG,
  output logic       MUSIC_STATUS,
  output logic       SPEECH_STATUS,
  output logic       PSG_OVR
);

  localparam int TW = $clog2(TRIG_TIMEOUT + 1);
  localparam int CW = $clog2(ALLO_DEPTH) + 1;

  psg_state_t    p_state, p_next;
  logic [3:0]    tick_cnt, tick_nxt;
  logic [7:0]    data_q;
  logic          psg_acc;
  logic          psg_take;

  spk_state_t    s_state, s_next;
  logic [TW-1:0] wait_cnt, wait_nxt;
  logic          spk_pop;
  logic          spk_push;
  logic [5:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;

  assign psg_acc  = CLK_EN && PSG_REQ;
  assign psg_take = (p_state == P_IDLE) && psg_acc;

  always_comb begin
    p_next   = p_state;
    tick_nxt = tick_cnt;
    case (p_state)
      P_IDLE: begin
        if (psg_acc) begin
          p_next   = P_LATCH;
          tick_nxt = '0;
        end
      end
      P_LATCH, P_WRITE: begin
        if (PSG_CE) begin
          if (tick_cnt == 4'(HOLD_TICKS - 1)) begin
            p_next   = (p_state == P_LATCH) ? P_GAP1 : P_GAP2;
            tick_nxt = '0;
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
      end
      P_GAP1:  if (PSG_CE) p_next = P_WRITE;
      P_GAP2:  if (PSG_CE) p_next = P_IDLE;
      default: p_next = P_IDLE;
    endcase
  end

  // Bus pins follow the next state so they change on the same edge as the FSM.
  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      p_state          <= P_IDLE;
      tick_cnt         <= '0;
      data_q           <= '0;
      {YM_BDIR, YM_BC} <= BUS_INACT;
      YM_DATA          <= '0;
      PSG_OVR          <= 1'b0;
    end else if (SOFT_RST) begin
      p_state          <= P_IDLE;
      tick_cnt         <= '0;
      data_q           <= '0;
      {YM_BDIR, YM_BC} <= BUS_INACT;
      YM_DATA          <= '0;
      PSG_OVR          <= 1'b0;
    end else begin
      p_state          <= p_next;
      tick_cnt         <= tick_nxt;
      {YM_BDIR, YM_BC} <= bus_mode(p_next);
      if (psg_take) begin
        data_q  <= PSG_DATA;
        YM_DATA <= {4'h0, PSG_ADDR};
      end else if (p_state == P_GAP1 && p_next == P_WRITE) begin
        YM_DATA <= data_q;
      end
      if (p_state != P_IDLE && psg_acc) PSG_OVR <= 1'b1;
    end
  end

  assign MUSIC_STATUS = (p_state != P_IDLE);

  assign spk_pop  = (s_state == S_IDLE) && !fifo_empty && SP_INPUT_RDY;
  assign spk_push = CLK_EN && SPK_REQ && (!fifo_full || spk_pop);

  ms_allo_fifo #(
    .DW    (6),
    .DEPTH (ALLO_DEPTH)
  ) u_allo_fifo (
    .clk     (CLK),
    .reset_n (RESET_N),
    .clr     (SOFT_RST),
    .push    (spk_push),
    .pop     (spk_pop),
    .din     (SPK_ALLO),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  always_comb begin
    s_next   = s_state;
    wait_nxt = wait_cnt;
    case (s_state)
      S_IDLE: if (spk_pop) s_next = S_TRIG;
      S_TRIG: begin
        s_next   = S_WAIT;
        wait_nxt = '0;
      end
      S_WAIT: begin
        // Give the chip a bounded window to acknowledge by dropping INPUT_RDY.
        if (!SP_INPUT_RDY || wait_cnt == TW'(TRIG_TIMEOUT - 1)) s_next = S_IDLE;
        else wait_nxt = wait_cnt + 1'b1;
      end
      default: s_next = S_IDLE;
    endcase
  end

  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s_state  <= S_IDLE;
      wait_cnt <= '0;
      SP_ALLO  <= '0;
      SP_TRIG  <= 1'b0;
    end else if (SOFT_RST) begin
      s_state  <= S_IDLE;
      wait_cnt <= '0;
      SP_ALLO  <= '0;
      SP_TRIG  <= 1'b0;
    end else begin
      s_state  <= s_next;
      wait_cnt <= wait_nxt;
      SP_TRIG  <= (s_next == S_TRIG);
      if (spk_pop) SP_ALLO <= fifo_dout;
    end
  end

  assign SPEECH_STATUS = (fifo_cnt != '0) || (s_state != S_IDLE) || !SP_INPUT_RDY;

endmodule

// File: tb/tb_ms_sound_bus_ctrl.sv
// Bench for ms_sound_bus_ctrl: directed scenarios plus random traffic, every cycle
// compared against a phase/queue reference model (depth follows MS_ALLO_FIFO_EN).
module tb_ms_sound_bus_ctrl;

  localparam int HOLD = 2;
  localparam int TO   = 8;
`ifdef MS_ALLO_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_rst, clk_en, psg_ce, psg_req, spk_req, rdy;
  logic [3:0] psg_addr;
  logic [7:0] psg_data;
  logic [5:0] spk_allo;
  logic       ym_bdir, ym_bc, sp_trig, music_status, speech_status, psg_ovr;
  logic [7:0] ym_data;
  logic [5:0] sp_allo;

  ms_sound_bus_ctrl #(
    .HOLD_TICKS   (HOLD),
    .ALLO_DEPTH   (4),
    .TRIG_TIMEOUT (TO)
  ) dut (
    .CLK           (clk),
    .RESET_N       (rst_n),
    .SOFT_RST      (soft_rst),
    .CLK_EN        (clk_en),
    .PSG_CE        (psg_ce),
    .PSG_REQ       (psg_req),
    .PSG_ADDR      (psg_addr),
    .PSG_DATA      (psg_data),
    .SPK_REQ       (spk_req),
    .SPK_ALLO      (spk_allo),
    .SP_INPUT_RDY  (rdy),
    .YM_BDIR       (ym_bdir),
    .YM_BC         (ym_bc),
    .YM_DATA       (ym_data),
    .SP_ALLO       (sp_allo),
    .SP_TRIG       (sp_trig),
    .MUSIC_STATUS  (music_status),
    .SPEECH_STATUS (speech_status),
    .PSG_OVR       (psg_ovr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a write is a list of four phases, each lasting a number of
  // PSG_CE ticks; speech is a bounded queue feeding a trigger/wait handshake.
  bit         m_busy;
  int         m_ph, m_cnt;
  logic [7:0] m_data, m_ydata;
  bit         m_ovr;
  logic [5:0] q[$];
  int         m_st;   // 0 idle, 1 strobe, 2 awaiting acknowledge
  int         m_w;
  logic [5:0] m_allo;
  bit         m_trig;

  function automatic int need(input int ph);
    return (ph == 0 || ph == 2) ? HOLD : 1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n || soft_rst) begin
      m_busy = 0; m_ph = 0; m_cnt = 0; m_data = 0; m_ydata = 0; m_ovr = 0;
      q.delete(); m_st = 0; m_w = 0; m_allo = 0; m_trig = 0;
    end else begin
      bit pop, full;
      if (m_busy) begin
        if (clk_en && psg_req) m_ovr = 1;
        if (psg_ce) begin
          m_cnt++;
          if (m_cnt == need(m_ph)) begin
            m_cnt = 0;
            m_ph++;
            if (m_ph == 2) m_ydata = m_data;
            if (m_ph == 4) m_busy = 0;
          end
        end
      end else if (clk_en && psg_req) begin
        m_busy = 1; m_ph = 0; m_cnt = 0; m_data = psg_data; m_ydata = {4'h0, psg_addr};
      end
      pop  = (m_st == 0) && (q.size() > 0) && rdy;
      full = (q.size() >= DEPTH);
      if (pop) m_allo = q.pop_front();
      if (clk_en && spk_req && (!full || pop)) q.push_back(spk_allo);
      case (m_st)
        0: if (pop) m_st = 1;
        1: begin m_st = 2; m_w = 0; end
        default: if (!rdy || m_w == TO - 1) m_st = 0; else m_w++;
      endcase
      m_trig = (m_st == 1);
    end
  end

  task automatic compare_all();
    chk("bdir",   ym_bdir, m_busy && (m_ph == 0 || m_ph == 2));
    chk("bc",     ym_bc,   m_busy && (m_ph == 0));
    chk("ydata",  ym_data, m_ydata);
    chk("music",  music_status, m_busy);
    chk("ovr",    psg_ovr, m_ovr);
    chk("trig",   sp_trig, m_trig);
    chk("allo",   sp_allo, m_allo);
    chk("speech", speech_status, (q.size() > 0) || (m_st != 0) || !rdy);
  endtask

  int         cyc_n = 0;
  bit         ce_rand = 0;
  int         lat_t, gap_t, wr_t;
  logic [5:0] obs[$];
  int         obs_t[$];

  task automatic step();
    @(posedge clk);
    compare_all();
    if (sp_trig) begin
      obs.push_back(sp_allo);
      obs_t.push_back(cyc_n);
    end
    cyc_n++;
    psg_ce = ce_rand ? ($urandom_range(0, 2) == 0) : (cyc_n % 4 == 0);
    if (music_status && psg_ce) begin
      case ({ym_bdir, ym_bc})
        2'b11:   lat_t++;
        2'b10:   wr_t++;
        default: gap_t++;
      endcase
    end
  endtask

  task automatic psg_write(input logic [3:0] a, input logic [7:0] d);
    psg_req = 1; psg_addr = a; psg_data = d;
    step();
    psg_req = 0;
  endtask

  task automatic wait_music_idle(input string tag);
    int n = 0;
    while (music_status && n < 200) begin step(); n++; end
    chk(tag, music_status, 0);
  endtask

  initial begin
    rst_n = 0; soft_rst = 0; clk_en = 0; psg_ce = 0; psg_req = 0; spk_req = 0;
    rdy = 0; psg_addr = 0; psg_data = 0; spk_allo = 0;
    repeat (3) step();
    chk("rst_speech_rdy0", speech_status, 1);
    rdy = 1;
    step();
    chk("rst_speech_rdy1", speech_status, 0);
    chk("rst_bus", {ym_bdir, ym_bc, ym_data}, 0);
    rst_n = 1;
    clk_en = 1;
    step();

    // Single write: addr 7, data 0x3E
    lat_t = 0; gap_t = 0; wr_t = 0;
    psg_write(4'd7, 8'h3E);
    chk("accept_bdir", {ym_bdir, ym_bc, ym_data}, {2'b11, 8'h07});
    wait_music_idle("write1_done");
    chk("latch_ticks", lat_t, HOLD);
    chk("gap_ticks",   gap_t, 2);
    chk("write_ticks", wr_t,  HOLD);
    chk("ovr_clean",   psg_ovr, 0);

    // Request one tick into a cycle is dropped
    lat_t = 0; gap_t = 0; wr_t = 0;
    psg_write(4'd2, 8'hA5);
    for (int n = 0; n < 50 && lat_t < 1; n++) step();
    psg_write(4'd9, 8'h55);
    chk("ovr_set", psg_ovr, 1);
    wait_music_idle("write2_done");
    chk("latch_ticks2", lat_t, HOLD);
    chk("write_ticks2", wr_t,  HOLD);
    chk("ydata_kept", ym_data, 8'hA5);

    // Queue five allophones while the chip is busy, then push alongside a pop
    rdy = 0; obs.delete(); obs_t.delete();
    for (int i = 1; i <= 5; i++) begin
      spk_req = 1; spk_allo = 6'(i);
      step();
    end
    spk_req = 0;
    step();
    rdy = 1; spk_req = 1; spk_allo = 6'h2A;
    step();
    spk_req = 0;
    begin
      int low = 0;
      int seen = 0;
      for (int n = 0; n < 150; n++) begin
        step();
        if (obs.size() != seen) begin seen = obs.size(); low = 2; end
        rdy = (low == 0);
        if (low > 0) low--;
      end
    end
    begin
      logic [5:0] exp_seq[$];
      for (int i = 1; i <= DEPTH && i <= 4; i++) exp_seq.push_back(6'(i));
      exp_seq.push_back(6'h2A);
      chk("trig_count", obs.size(), exp_seq.size());
      for (int i = 0; i < exp_seq.size() && i < obs.size(); i++)
        chk($sformatf("trig_seq%0d", i), obs[i], exp_seq[i]);
    end

    // Chip never acknowledges: wait window expires, next pop follows
    rdy = 1; obs.delete(); obs_t.delete();
    spk_req = 1; spk_allo = 6'h11; step();
    spk_allo = 6'h12; step();
    spk_req = 0;
    for (int n = 0; n < 40; n++) step();
    chk("to_count", obs.size(), 2);
    if (obs.size() == 2) chk("to_gap", obs_t[1] - obs_t[0], TO + 2);

    // Soft reset while the write phase is on the bus
    rdy = 0;
    spk_req = 1; spk_allo = 6'h3C; step();
    spk_req = 0;
    psg_write(4'd5, 8'hC3);
    begin
      int n = 0;
      while (!(ym_bdir && !ym_bc) && n < 100) begin step(); n++; end
      chk("reach_write", {ym_bdir, ym_bc}, 2'b10);
    end
    chk("ovr_before_srst", psg_ovr, 1);
    rdy = 1; soft_rst = 1;
    step();
    soft_rst = 0;
    chk("srst_bus",    {ym_bdir, ym_bc, ym_data}, 0);
    chk("srst_ovr",    psg_ovr, 0);
    chk("srst_music",  music_status, 0);
    chk("srst_speech", speech_status, 0);
    step();

    // Random traffic
    ce_rand = 1;
    for (int n = 0; n < 4000; n++) begin
      step();
      clk_en   = ($urandom_range(0, 1) == 0);
      psg_req  = ($urandom_range(0, 7) == 0);
      psg_addr = 4'($urandom);
      psg_data = 8'($urandom);
      spk_req  = ($urandom_range(0, 3) == 0);
      spk_allo = 6'($urandom);
      if ($urandom_range(0, 4) == 0) rdy = ~rdy;
      soft_rst = ($urandom_range(0, 299) == 0);
    end
    soft_rst = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
